// File: rtl/cache_wb_engine.sv
// Write-back / eviction engine for a single cache line register group.
// Reads the line status on request, streams a valid+dirty line to memory as
// BEAT_WIDTH beats (address, data, response channels with valid/ready), then
// clears valid, dirty and evict-pending through the line group's enables.
// Build option: define CACHE_WB_SNAPSHOT_EN to copy the line data into an
// internal buffer at accept, so the line may change right after accept.
// Without it, beats are taken live from line_data_i.
//
// state | meaning
// IDLE  | waiting for an eviction request, req_ready_o high
// ADDR  | presenting the write-back address
// DATA  | streaming beats, beat counter k selects the slice
// RESP  | waiting for the memory write response
// CLEAR | one-cycle completion: pulse enables, done_o, err_o
module cache_wb_engine #(
  parameter  int TAG_BITS   = 51,
  parameter  int DATA_WIDTH = 1024,
  parameter  int BEAT_WIDTH = 64,
  localparam int BEATS      = DATA_WIDTH / BEAT_WIDTH,
  localparam int OFF_BITS   = $clog2(DATA_WIDTH / 8)
) (
  input  logic                         clk_i,
  input  logic                         arst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [TAG_BITS-1:0]          line_tag_i,
  input  logic                         line_val_i,
  input  logic                         line_dirty_i,
  input  logic                         line_evp_i,
  input  logic [DATA_WIDTH-1:0]        line_data_i,
  output logic                         val_en_o,
  output logic                         val_o,
  output logic                         dirty_en_o,
  output logic                         dirty_o,
  output logic                         evp_en_o,
  output logic                         evp_o,
  output logic                         mem_addr_valid_o,
  input  logic                         mem_addr_ready_i,
  output logic [TAG_BITS+OFF_BITS-1:0] mem_addr_o,
  output logic                         mem_data_valid_o,
  input  logic                         mem_data_ready_i,
  output logic [BEAT_WIDTH-1:0]        mem_data_o,
  output logic                         mem_data_last_o,
  input  logic                         mem_resp_valid_i,
  output logic                         mem_resp_ready_o,
  input  logic                         mem_resp_err_i,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int K_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_CLEAR
  } state_t;

  state_t                state_q, state_d;
  logic [TAG_BITS-1:0]   tag_q;
  logic [K_BITS-1:0]     k_q;
  logic                  err_q;
  logic                  accept;
  logic                  beat_hs;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] line_src;

  // Evict-pending is informational only; it never gates a request.
  logic unused_evp;
  assign unused_evp = line_evp_i;

  assign accept    = (state_q == S_IDLE) && req_valid_i;
  assign beat_hs   = (state_q == S_DATA) && mem_data_ready_i;
  assign last_beat = (k_q == K_BITS'(BEATS - 1));

`ifdef CACHE_WB_SNAPSHOT_EN
  logic [DATA_WIDTH-1:0] data_q;

  // Line snapshot taken at accept so the group can be refilled after done_o.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= line_data_i;
    end
  end

  assign line_src = data_q;
`else
  assign line_src = line_data_i;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured tag, beat counter and response error flag.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      tag_q <= '0;
      k_q   <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        tag_q <= line_tag_i;
        err_q <= 1'b0;
      end
      if (beat_hs) begin
        k_q <= last_beat ? '0 : k_q + 1'b1;
      end
      if ((state_q == S_RESP) && mem_resp_valid_i) begin
        err_q <= mem_resp_err_i;
      end
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_d          = state_q;
    req_ready_o      = 1'b0;
    mem_addr_valid_o = 1'b0;
    mem_data_valid_o = 1'b0;
    mem_data_last_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    done_o           = 1'b0;
    err_o            = 1'b0;
    val_en_o         = 1'b0;
    dirty_en_o       = 1'b0;
    evp_en_o         = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = (line_val_i && line_dirty_i) ? S_ADDR : S_CLEAR;
        end
      end
      S_ADDR: begin
        mem_addr_valid_o = 1'b1;
        if (mem_addr_ready_i) state_d = S_DATA;
      end
      S_DATA: begin
        mem_data_valid_o = 1'b1;
        mem_data_last_o  = last_beat;
        if (mem_data_ready_i && last_beat) state_d = S_RESP;
      end
      S_RESP: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        // On a memory error the line stays valid and dirty for a retry.
        done_o     = 1'b1;
        err_o      = err_q;
        evp_en_o   = 1'b1;
        val_en_o   = !err_q;
        dirty_en_o = !err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign val_o      = 1'b0;
  assign dirty_o    = 1'b0;
  assign evp_o      = 1'b0;
  assign mem_addr_o = {tag_q, {OFF_BITS{1'b0}}};
  assign mem_data_o = (state_q == S_DATA) ?
                      line_src[int'(k_q)*BEAT_WIDTH +: BEAT_WIDTH] : '0;

endmodule

// File: tb/tb_cache_wb_engine.sv
// Scoreboard bench for cache_wb_engine with default parameters
// (51-bit tag, 1024-bit line, 16 beats of 64 bits, 7 offset bits).
module tb_cache_wb_engine;

  localparam int TAG_BITS   = 51;
  localparam int DATA_WIDTH = 1024;
  localparam int BEAT_WIDTH = 64;
  localparam int BEATS      = 16;
  localparam int OFF_BITS   = 7;

  logic                         clk_i = 1'b0;
  logic                         arst_ni;
  logic                         req_valid_i;
  logic                         req_ready_o;
  logic [TAG_BITS-1:0]          line_tag_i;
  logic                         line_val_i, line_dirty_i, line_evp_i;
  logic [DATA_WIDTH-1:0]        line_data_i;
  logic                         val_en_o, val_o, dirty_en_o, dirty_o, evp_en_o, evp_o;
  logic                         mem_addr_valid_o, mem_addr_ready_i;
  logic [TAG_BITS+OFF_BITS-1:0] mem_addr_o;
  logic                         mem_data_valid_o, mem_data_ready_i;
  logic [BEAT_WIDTH-1:0]        mem_data_o;
  logic                         mem_data_last_o;
  logic                         mem_resp_valid_i, mem_resp_ready_o, mem_resp_err_i;
  logic                         done_o, err_o;

  cache_wb_engine dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .line_tag_i(line_tag_i), .line_val_i(line_val_i), .line_dirty_i(line_dirty_i),
    .line_evp_i(line_evp_i), .line_data_i(line_data_i),
    .val_en_o(val_en_o), .val_o(val_o), .dirty_en_o(dirty_en_o), .dirty_o(dirty_o),
    .evp_en_o(evp_en_o), .evp_o(evp_o),
    .mem_addr_valid_o(mem_addr_valid_o), .mem_addr_ready_i(mem_addr_ready_i),
    .mem_addr_o(mem_addr_o),
    .mem_data_valid_o(mem_data_valid_o), .mem_data_ready_i(mem_data_ready_i),
    .mem_data_o(mem_data_o), .mem_data_last_o(mem_data_last_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_resp_err_i(mem_resp_err_i),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic err;
    int   cyc;
  } done_t;

  beat_t       exp_beats[$];
  done_t       exp_done[$];
  logic [63:0] exp_addr[$];

  int   n_checks   = 0;
  int   n_pass     = 0;
  int   n_done     = 0;
  int   beats_seen = 0;
  logic prev_done  = 1'b0;
  logic bp_data    = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mk_line(input logic [63:0] base, input logic [63:0] step);
    logic [DATA_WIDTH-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*64 +: 64] = base + 64'(k) * step;
    return l;
  endfunction

  task automatic push_beats(input logic [63:0] base, input logic [63:0] step);
    beat_t b;
    for (int k = 0; k < BEATS; k++) begin
      b.data = base + 64'(k) * step;
      b.last = (k == BEATS - 1);
      exp_beats.push_back(b);
    end
  endtask

  // Issue one request; caller sits just after a rising edge with the engine idle.
  task automatic request(input logic [TAG_BITS-1:0] tag, input logic v, input logic d,
                         input logic evp, input logic [DATA_WIDTH-1:0] data,
                         input logic err, input int lat);
    done_t e;
    line_tag_i     = tag;
    line_val_i     = v;
    line_dirty_i   = d;
    line_evp_i     = evp;
    line_data_i    = data;
    mem_resp_err_i = err;
    if (v && d) exp_addr.push_back(64'({tag, 7'b0}));
    e.err = err & v & d;
    e.cyc = (lat >= 0) ? cyc + lat : -1;
    exp_done.push_back(e);
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int   start = n_done;
    logic got   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      #1;
      if (n_done > start) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 64'(got), 64'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_valids"}, 64'({mem_addr_valid_o, mem_data_valid_o, mem_resp_ready_o, mem_data_last_o}), 64'd0);
    chk({tag, "_enables"}, 64'({val_en_o, dirty_en_o, evp_en_o, done_o, err_o}), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
    chk({tag, "_data"}, mem_data_o, 64'd0);
  endtask

  // Data-channel ready: always high, or toggling every cycle under backpressure.
  initial begin
    mem_data_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1 mem_data_ready_i = bp_data ? ~mem_data_ready_i : 1'b1;
    end
  end

  // Monitor: compares every handshake and completion against the queues.
  always @(negedge clk_i) begin
    done_t e;
    if (arst_ni) begin
      if (prev_done) chk("ready_after_done", 64'(req_ready_o), 64'd1);
      prev_done = done_o;
      if (mem_addr_valid_o && mem_addr_ready_i) begin
        if (exp_addr.size() == 0) chk("unexpected_addr", 64'd1, 64'd0);
        else chk("addr", 64'(mem_addr_o), exp_addr.pop_front());
      end
      if (mem_data_valid_o) begin
        if (exp_beats.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          chk(mem_data_ready_i ? "beat_data" : "stalled_data", mem_data_o, exp_beats[0].data);
          chk("beat_last", 64'(mem_data_last_o), 64'(exp_beats[0].last));
          if (mem_data_ready_i) begin
            void'(exp_beats.pop_front());
            beats_seen++;
          end
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          e = exp_done.pop_front();
          chk("err", 64'(err_o), 64'(e.err));
          chk("val_en", 64'(val_en_o), 64'(!e.err));
          chk("dirty_en", 64'(dirty_en_o), 64'(!e.err));
          chk("evp_en", 64'(evp_en_o), 64'd1);
          chk("clear_data", 64'({val_o, dirty_o, evp_o}), 64'd0);
          if (e.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
        n_done++;
      end else if (val_en_o || dirty_en_o || evp_en_o || err_o) begin
        chk("stray_enable", 64'd1, 64'd0);
      end
    end
  end

  initial begin
    int b0;
    int got_beat5;
    arst_ni          = 1'b0;
    req_valid_i      = 1'b0;
    line_tag_i       = '0;
    line_val_i       = 1'b0;
    line_dirty_i     = 1'b0;
    line_evp_i       = 1'b0;
    line_data_i      = '0;
    mem_addr_ready_i = 1'b1;
    mem_resp_valid_i = 1'b1;   // held high: must be ignored outside RESP
    mem_resp_err_i   = 1'b0;

    #1 check_reset_vals("reset");
    repeat (2) @(posedge clk_i);
    #1 arst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Clean valid line: no memory traffic, done one cycle after accept.
    request(51'h55, 1'b1, 1'b0, 1'b1, mk_line(64'hDEAD, 64'd3), 1'b0, 1);
    wait_done("clean_done");

    // Invalid but dirty line: also no traffic.
    request(51'h1, 1'b0, 1'b1, 1'b0, mk_line(64'h0, 64'd1), 1'b0, 1);
    wait_done("invalid_done");

    // Dirty line, tag 1, beat k carries k, no backpressure: done at T+19.
    push_beats(64'd0, 64'd1);
    request(51'h1, 1'b1, 1'b1, 1'b0, mk_line(64'd0, 64'd1), 1'b0, 19);
    wait_done("dirty_done");

    // Data ready toggling: same beats, stalled outputs stable, 16 handshakes.
    b0 = beats_seen;
    bp_data = 1'b1;
    push_beats(64'h1111_0000_0000_0000, 64'h0101_0101_0101_0101);
    request(51'h3ABC, 1'b1, 1'b1, 1'b1,
            mk_line(64'h1111_0000_0000_0000, 64'h0101_0101_0101_0101), 1'b0, -1);
    wait_done("bp_done");
    bp_data = 1'b0;
    chk("bp_handshakes", 64'(beats_seen - b0), 64'd16);

    // Memory error: line kept valid and dirty, evict-pending still cleared.
    push_beats(64'hA5A5_0000_0000_0000, 64'd7);
    request(51'h7_1234_5678, 1'b1, 1'b1, 1'b1, mk_line(64'hA5A5_0000_0000_0000, 64'd7), 1'b1, 19);
    wait_done("err_done");
    mem_resp_err_i = 1'b0;

    // Reset while streaming beat 5: immediate abort, then a clean restart.
    b0 = beats_seen;
    got_beat5 = 0;
    push_beats(64'hC0DE_0000_0000_0000, 64'd1);
    request(51'h9, 1'b1, 1'b1, 1'b0, mk_line(64'hC0DE_0000_0000_0000, 64'd1), 1'b0, -1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      #1;
      if (beats_seen >= b0 + 5) begin
        got_beat5 = 1;
        break;
      end
    end
    chk("reach_beat5", 64'(got_beat5), 64'd1);
    @(posedge clk_i);
    #2 arst_ni = 1'b0;
    exp_beats.delete();
    exp_done.delete();
    exp_addr.delete();
    #1 check_reset_vals("midreset");
    repeat (2) @(posedge clk_i);
    #1 arst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    push_beats(64'h0BAD_0000_0000_0000, 64'd2);
    request(51'h2, 1'b1, 1'b1, 1'b0, mk_line(64'h0BAD_0000_0000_0000, 64'd2), 1'b0, 19);
    wait_done("restart_done");

`ifdef CACHE_WB_SNAPSHOT_EN
    // Line data replaced one cycle after accept: stream carries the old data.
    push_beats(64'h5A5A_0000_0000_0000, 64'd5);
    request(51'h4, 1'b1, 1'b1, 1'b0, mk_line(64'h5A5A_0000_0000_0000, 64'd5), 1'b0, 19);
    line_data_i = mk_line(64'hFFFF_0000_0000_0000, 64'd9);
    wait_done("snapshot_done");
`endif

    chk("leftover_beats", 64'(exp_beats.size()), 64'd0);
    chk("leftover_addr", 64'(exp_addr.size()), 64'd0);
    chk("leftover_done", 64'(exp_done.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/cache_wb_engine.md
# cache_wb_engine

Write-back/eviction engine for one cache line register group. On request it reads the line's tag, valid, dirty, evict-pending and data outputs. If the line is valid and dirty it writes the line to memory over a valid/ready address, data and response channel. It then drives the group's enable/data inputs to clear valid, dirty and evict-pending. It sits between the line storage and the memory-side write port, alongside the cache controller that issues eviction requests.

## Interface
Parameters:
- TAG_BITS, 51, line tag width
- DATA_WIDTH, 1024, line data width in bits
- BEAT_WIDTH, 64, memory data beat width; power of 2, ≥8, divides DATA_WIDTH
- Derived, not overridable: BEATS = DATA_WIDTH/BEAT_WIDTH; OFF_BITS = $clog2(DATA_WIDTH/8)

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  eviction request
- req_ready_o  out  1  engine idle, request accepted when both high
- line_tag_i  in  TAG_BITS  tag from line group
- line_val_i, line_dirty_i, line_evp_i  in  1 each  line status bits
- line_data_i  in  DATA_WIDTH  line data
- val_en_o / val_o, dirty_en_o / dirty_o, evp_en_o / evp_o  out  1 each  write enables and data into line group
- mem_addr_valid_o  out  1; mem_addr_ready_i  in  1; mem_addr_o  out  TAG_BITS+OFF_BITS  = {tag, OFF_BITS'0}
- mem_data_valid_o  out  1; mem_data_ready_i  in  1; mem_data_o  out  BEAT_WIDTH; mem_data_last_o  out  1
- mem_resp_valid_i  in  1; mem_resp_ready_o  out  1; mem_resp_err_i  in  1
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  qualifies done_o; memory returned error

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, CLEAR.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture tag, val and dirty.
  - Next state is ADDR if val&&dirty, else CLEAR.
  - line_evp_i is informational only and does not gate the request.
- ADDR: mem_addr_valid_o=1 with the captured address; on mem_addr_ready_i go to DATA.
- DATA:
  - mem_data_valid_o=1; mem_data_o = captured line bits [k*BEAT_WIDTH +: BEAT_WIDTH], where k is the beat counter (0..BEATS-1).
  - Beat 0 is the least significant beat.
  - k increments on each handshake.
  - mem_data_last_o=1 when k==BEATS-1.
  - The handshake on the last beat moves to RESP and resets k to 0.
- RESP: mem_resp_ready_o=1; on mem_resp_valid_i latch mem_resp_err_i and go to CLEAR.
- CLEAR, exactly one cycle, then IDLE:
  - done_o=1.
  - evp_en_o=1, evp_o=0, always.
  - On success or a clean/invalid line: val_en_o=1, val_o=0, dirty_en_o=1, dirty_o=0.
  - On error: val_en_o=0, dirty_en_o=0, so the line is kept valid and dirty; err_o=1.
- val_o, dirty_o and evp_o are constant 0; only the enables toggle.
- Outputs on the address, data and response channels are held stable while their valid is high and ready is low.

## Timing
- Reset values:
  - state IDLE, k=0.
  - req_ready_o=1.
  - All valids, enables, done_o, err_o, mem_data_last_o and mem_resp_ready_o are 0.
  - Data/address outputs are 0.
- Reset mid-operation aborts immediately with no clear pulse; line state is untouched.
- Clean-line latency: accept at T, CLEAR/done_o at T+1, req_ready_o at T+2.
- Dirty line with no backpressure:
  - accept at T;
  - address at T+1;
  - beats at T+2..T+1+BEATS;
  - response accepted at T+2+BEATS;
  - done_o at T+3+BEATS.
- mem_resp_valid_i outside RESP is ignored, since mem_resp_ready_o=0 there.
- req_valid_i while busy is ignored, since req_ready_o=0.
- The line group sees the enables in the CLEAR cycle; cleared values appear on its outputs the following cycle.
- Backpressure on any channel stalls only that state; there is no timeout.

## Configuration
- CACHE_WB_SNAPSHOT_EN defined:
  - line_data_i is captured into an internal DATA_WIDTH buffer at accept.
  - The line group may be refilled as soon as done_o is observed.
  - line_data_i changes after accept have no effect.
- Not defined:
  - No data buffer; beats are muxed live from line_data_i.
  - The requester must hold the line stable from accept until done_o.
  - Tag is still captured at accept.

## Test plan
- Clean line (val=1, dirty=0), req at T -> no memory traffic; done_o at T+1 with val_en_o=dirty_en_o=evp_en_o=1 and err_o=0.
- Dirty line, tag=0x1, data beat k = 64'hk, all readies high:
  - mem_addr_o=0x80;
  - 16 beats carrying values 0..15, last asserted only on beat 15;
  - done_o at T+19.
- Dirty line with mem_data_ready_i toggling every other cycle -> beat values and order unchanged; data outputs stable while stalled; 16 handshakes exactly.
- Response with mem_resp_err_i=1 -> done_o=1 and err_o=1; evp_en_o=1; val_en_o=dirty_en_o=0.
- arst_ni low during DATA at beat 5 -> immediate return to reset values, no enables pulsed; a new request then restarts from beat 0.
- With CACHE_WB_SNAPSHOT_EN, change line_data_i one cycle after accept -> streamed beats equal the pre-change data.
